// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : iitb_wb_pkg
// Brief   : WB control field encodings, arbiter state type and default widths
// Rev     : 1.0
// ============================================================================
package iitb_wb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_CNT_W  = 16;

  localparam int         WB_WE_BIT   = 2;
  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_MEM  = 2'b01;
  localparam logic [1:0] WB_SRC_ZPAD = 2'b10;
  localparam logic [1:0] WB_SRC_PC1  = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : wb_port_arbiter_if
// Brief     : Both lanes' M/WB outputs plus the register-file write port
// Rev       : 1.0
// ============================================================================
interface wb_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
);
  logic              valid0, valid1;
  logic [2:0]        wb0, wb1;
  logic [DATA_W-1:0] alu0, alu1, mem0, mem1, zpad0, zpad1, pc1_0, pc1_1;
  logic [ADDR_W-1:0] dest0, dest1;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              m_wb_enable;
  logic [CNT_W-1:0]  retired;

  modport master (
    output valid0, valid1, wb0, wb1, alu0, alu1, mem0, mem1,
           zpad0, zpad1, pc1_0, pc1_1, dest0, dest1,
    input  rf_we, rf_addr, rf_data, m_wb_enable, retired
  );

  modport slave (
    input  valid0, valid1, wb0, wb1, alu0, alu1, mem0, mem1,
           zpad0, zpad1, pc1_0, pc1_1, dest0, dest1,
    output rf_we, rf_addr, rf_data, m_wb_enable, retired
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter_src_mux.sv
`default_nettype none
// ============================================================================
// Module : wb_src_mux
// Brief  : 4:1 writeback source select on wb[1:0]
// Rev    : 1.0
// ============================================================================
module wb_src_mux
  import iitb_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  wire logic [1:0]        sel_i,
  input  wire logic [DATA_W-1:0] alu_i,
  input  wire logic [DATA_W-1:0] mem_i,
  input  wire logic [DATA_W-1:0] zpad_i,
  input  wire logic [DATA_W-1:0] pc1_i,
  output logic      [DATA_W-1:0] data_o
);
  always_comb begin
    data_o = alu_i;
    case (sel_i)
      WB_SRC_ALU:  data_o = alu_i;
      WB_SRC_MEM:  data_o = mem_i;
      WB_SRC_ZPAD: data_o = zpad_i;
      WB_SRC_PC1:  data_o = pc1_i;
      default:     data_o = alu_i;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_port_arbiter
// Brief  : Serialises two lanes' writebacks onto one RF write port, stalling
//          M/WB for a drain cycle; optional WB_ARB_COALESCE_EN merges
//          same-destination pairs into the younger write.
// Rev    : 1.0
// ============================================================================
module wb_port_arbiter
  import iitb_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input wire logic     clock,
  input wire logic     reset,
  wb_port_arbiter_if.slave bus
);
  wb_arb_state_t     state_q, state_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              req0, req1, same_dest;
  logic [DATA_W-1:0] data0, data1;
  logic [1:0]        retire_inc;

  assign req0 = bus.valid0 & bus.wb0[WB_WE_BIT];
  assign req1 = bus.valid1 & bus.wb1[WB_WE_BIT];

`ifdef WB_ARB_COALESCE_EN
  assign same_dest = (bus.dest0 == bus.dest1);
`else
  assign same_dest = 1'b0;
`endif

  wb_src_mux #(.DATA_W(DATA_W)) u_mux0 (
    .sel_i(bus.wb0[1:0]), .alu_i(bus.alu0), .mem_i(bus.mem0),
    .zpad_i(bus.zpad0), .pc1_i(bus.pc1_0), .data_o(data0)
  );

  wb_src_mux #(.DATA_W(DATA_W)) u_mux1 (
    .sel_i(bus.wb1[1:0]), .alu_i(bus.alu1), .mem_i(bus.mem1),
    .zpad_i(bus.zpad1), .pc1_i(bus.pc1_1), .data_o(data1)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      retired_q   <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 && req1 && !same_dest) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1 && !same_dest) begin
          rf_we_d     = 1'b1;
          rf_addr_d   = bus.dest0;
          rf_data_d   = data0;
          hold_addr_d = bus.dest1;
          hold_data_d = data1;
        end else if (req1) begin
          // Covers lane 1 alone and a coalesced pair: the younger write wins.
          rf_we_d   = 1'b1;
          rf_addr_d = bus.dest1;
          rf_data_d = data1;
        end else if (req0) begin
          rf_we_d   = 1'b1;
          rf_addr_d = bus.dest0;
          rf_data_d = data0;
        end
      end
      DRAIN: begin
        rf_we_d   = 1'b1;
        rf_addr_d = hold_addr_q;
        rf_data_d = hold_data_q;
      end
      default: ;
    endcase
  end

  assign retire_inc = (state_q == IDLE) ? ({1'b0, bus.valid0} + {1'b0, bus.valid1}) : 2'd0;
  assign retired_d  = retired_q + CNT_W'(retire_inc);

  assign bus.m_wb_enable = (state_q == IDLE);
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_data     = rf_data_q;
  assign bus.retired     = retired_q;

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Writeback-port arbiter for the two-lane superscalar pipeline. It takes the outputs of both lanes' M/WB pipeline registers and selects each lane's writeback source. It serialises the writes onto the single register-file write port and drives the shared M/WB register `enable` to stall both lanes while a second write is drained. It also keeps a retired-instruction counter.

## Interface
- `DATA_W`, default 16: datapath width.
- `ADDR_W`, default 3: register address width.
- `CNT_W`, default 16: retired-counter width.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `valid0`/`valid1`  in  1  lane valid; lane 0 is older.
- `wb0`/`wb1`  in  3  WB control: `[2]` is register-write enable; `[1:0]` selects the source: 00 ALU, 01 memory read, 10 zero-pad, 11 PC+1.
- `alu0`/`alu1`, `mem0`/`mem1`, `zpad0`/`zpad1`, `pc1_0`/`pc1_1`  in  `DATA_W`  candidate writeback data.
- `dest0`/`dest1`  in  `ADDR_W`  destination register.
- `rf_we`  out  1  register-file write strobe (registered).
- `rf_addr`  out  `ADDR_W`  write address (registered).
- `rf_data`  out  `DATA_W`  write data (registered).
- `m_wb_enable`  out  1  enable to both M/WB registers; low means hold.
- `retired`  out  `CNT_W`  retired-instruction count.

## Operation
- `reqN = validN & wbN[2]`. `dataN` is the source selected by `wbN[1:0]`, full width, with no extension.
- **IDLE**:
  - No request: `rf_we` goes 0 at the next edge.
  - Exactly one request: that lane's write is registered to the `rf_*` outputs.
  - Both requests: lane 0's write is registered; lane 1's `dest`/`data` are captured in the hold register; next state is DRAIN.
- **DRAIN**:
  - The held lane-1 write is registered to the `rf_*` outputs.
  - Lane inputs are ignored.
  - Next state is IDLE.
- `m_wb_enable = (state == IDLE)`. It is a decode of the state register only, with no combinational path from lane inputs.
- `retired`:
  - Adds `valid0 + valid1` (0, 1 or 2) on every IDLE cycle.
  - Adds 0 in DRAIN.
  - Counts valid instructions whether or not they write a register.
  - Wraps modulo 2^`CNT_W` (0xFFFF + 2 gives 0x0001).
- Writes are always issued in program order: lane 0 before lane 1.

## Timing
- Latency is 1 cycle from the M/WB outputs to `rf_we`/`rf_addr`/`rf_data`.
- A dual-write pair holds `m_wb_enable` low for exactly 1 cycle (the DRAIN cycle). The M/WB contents present in DRAIN are consumed in the following IDLE cycle.
- Back-to-back dual pairs give the pattern IDLE, DRAIN, IDLE, DRAIN, with `m_wb_enable` toggling 1,0,1,0.
- Reset (asynchronous assert, synchronous release) forces:
  - state IDLE, hold register 0
  - `rf_we` 0, `rf_addr` 0, `rf_data` 0
  - `retired` 0
  - `m_wb_enable` 1
- A reset asserted in DRAIN discards the held write; no write is issued after release.
- `wbN[2]=1` with `validN=0` is not a request. `rf_we` stays 0 for that lane.

## Configuration
- `WB_ARB_COALESCE_EN` defined:
  - In IDLE with both requests and `dest0 == dest1`, only lane 1's write is registered.
  - No DRAIN, no stall.
  - `retired` still adds 2.
- Not defined: same-destination pairs are serialised like any dual pair (lane 0, then lane 1, with a 1-cycle stall).

## Structure
- Package `iitb_wb_pkg`:
  - WB field constants: `WB_WE_BIT`, `WB_SRC_ALU/MEM/ZPAD/PC1`.
  - State enum `wb_arb_state_t` {IDLE, DRAIN}.
  - Default widths.
- Sub-module `wb_src_mux`: combinational 4:1 source select on `wb[1:0]`. It is instantiated once per lane.
- The top level holds the FSM, hold register, output registers and counter.

## Test plan
- Lane 0 only: `valid0=1`, `wb0=3'b100`, `alu0=16'h1234`, `dest0=3` → next cycle `rf_we=1`, `rf_addr=3`, `rf_data=16'h1234`; `m_wb_enable` stays 1; `retired=1`.
- Dual write: lane 0 `wb=3'b101`, `mem0=16'hAAAA`, `dest0=1`; lane 1 `wb=3'b111`, `pc1_1=16'h0042`, `dest1=2` → cycle+1 writes r1=AAAA with `m_wb_enable=0`; cycle+2 writes r2=0042 with `m_wb_enable=1`; `retired=2`.
- Same destination, both lanes `dest=5`, lane 0 data 0x0011, lane 1 data 0x0022:
  - With `WB_ARB_COALESCE_EN`: single write r5=0x0022, no stall.
  - Without it: r5=0x0011, then r5=0x0022, with a 1-cycle stall.
- Non-writing valid instructions (`wb[2]=0`) on both lanes with `retired` preset near wrap at 0xFFFF → `rf_we` stays 0; `retired` becomes 0x0001.
- Reset pulse asserted mid-DRAIN → `rf_we=0`, `m_wb_enable=1`, `retired=0` immediately; no lane-1 write after release.
- Back-to-back dual pairs for 4 pairs → 8 writes in order, with `m_wb_enable` alternating 1,0.
